// File: rtl/data_pipe_pkg.sv
// Shared definitions for the data_pipe M2S path arbiter and its interconnect.
// Contents:
//   state_e    - arbiter FSM states
//   CNT_W      - width of the beat and idle counters (holds values up to 255)
//   calc_nsize - index width for N requesters, ceil(log2(N)) with a floor of 1
package data_pipe_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SWITCH  = 2'd1,
      ST_GRANT   = 2'd2,
      ST_RELEASE = 2'd3
   } state_e;

   localparam int CNT_W = 8;

   function automatic int calc_nsize(input int n);
      int w;
      w = 1;
      // The loop stops at 30 so that 1 << i stays positive.
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/data_pipe_m2s_arbiter_if.sv
// Handshake/selection bundle between the upstream requesters, the M2S
// interconnect and the path arbiter.
//   req, hs, last : per-requester valid, accepted beat, end of packet
//   curr_path     : path the interconnect has actually latched
//   sw, vld_sw    : selected path and "upstream ready enabled" on that path
//   grant, busy   : one-hot of sw while vld_sw, and arbiter not idle
// modport master : the arbiter (drives the selection)
// modport slave  : the interconnect/requester side
interface data_pipe_m2s_arbiter_if
   import data_pipe_pkg::*;
#(
   parameter int NUM   = 8,
   parameter int NSIZE = calc_nsize(NUM)
);
   logic [NUM-1:0]   req;
   logic [NUM-1:0]   hs;
   logic [NUM-1:0]   last;
   logic [NSIZE-1:0] curr_path;
   logic [NSIZE-1:0] sw;
   logic             vld_sw;
   logic [NUM-1:0]   grant;
   logic             busy;

   modport master (
      input  req, hs, last, curr_path,
      output sw, vld_sw, grant, busy
   );

   modport slave (
      output req, hs, last, curr_path,
      input  sw, vld_sw, grant, busy
   );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search.
//   req    : request vector
//   rr_ptr : index that has highest priority this round
//   winner : first requesting index at or after rr_ptr (wrapping modulo NUM)
//   found  : at least one request present
module rr_pick
   import data_pipe_pkg::*;
#(
   parameter int NUM   = 8,
   parameter int NSIZE = calc_nsize(NUM)
) (
   input  logic [NUM-1:0]   req,
   input  logic [NSIZE-1:0] rr_ptr,
   output logic [NSIZE-1:0] winner,
   output logic             found
);

   logic [NUM-1:0]   rot;
   logic [NSIZE-1:0] rot_k;
   logic [NSIZE:0]   sum;

   always_comb begin
      // rot[k] is req[(rr_ptr + k) mod NUM]: doubling the vector makes the wrap free.
      rot   = NUM'({req, req} >> rr_ptr);
      rot_k = '0;
      found = 1'b0;
      // Walk downwards so the smallest offset (closest to rr_ptr) wins.
      for (int k = NUM - 1; k >= 0; k--) begin
         if (rot[k]) begin
            rot_k = NSIZE'(k);
            found = 1'b1;
         end
      end
      sum = {1'b0, rr_ptr} + {1'b0, rot_k};
      if (sum >= (NSIZE + 1)'(NUM)) sum = sum - (NSIZE + 1)'(NUM);
      winner = sum[NSIZE-1:0];
   end

endmodule

// File: rtl/data_pipe_m2s_arbiter.sv
// Round-robin path arbiter for the data_pipe M2S interconnect.
// A winner is chosen in IDLE, the arbiter waits in SWITCH until the
// interconnect reports that path as latched, opens the path in GRANT until
// end of packet / burst limit / idle timeout, then spends one cycle in
// RELEASE advancing the round-robin pointer past the old owner.
// Ports:
//   clock  : clock
//   rst_n  : synchronous active-low reset (wins over clk_en)
//   clk_en : clock enable, all state advances only when high
//   bus    : master modport (req/hs/last/curr_path in, sw/vld_sw/grant/busy out)
// All outputs come straight from flops.
module data_pipe_m2s_arbiter
   import data_pipe_pkg::*;
#(
   parameter int NUM       = 8,
   parameter int NSIZE     = calc_nsize(NUM),
   parameter int BURST_MAX = 16,
   parameter int IDLE_TO   = 8
) (
   input  logic                    clock,
   input  logic                    rst_n,
   input  logic                    clk_en,
   data_pipe_m2s_arbiter_if.master bus
);

   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_MAX - 1);
   localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_TO - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = '1;

   state_e           state_q, state_d;
   logic [NSIZE-1:0] sw_q, sw_d;
   logic [NSIZE-1:0] rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
   logic             vld_sw_q, vld_sw_d;
   logic             busy_q, busy_d;
   logic [NUM-1:0]   grant_q, grant_d;

   logic [NSIZE-1:0] winner;
   logic             found;
   logic             sel_req, sel_hs, sel_last;

   rr_pick #(
      .NUM   (NUM),
      .NSIZE (NSIZE)
   ) u_rr_pick (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .winner (winner),
      .found  (found)
   );

   // Only the selected index matters; hs/last elsewhere are ignored.
   assign sel_req  = bus.req[sw_q];
   assign sel_hs   = bus.hs[sw_q];
   assign sel_last = bus.last[sw_q];

   always_comb begin
      state_d    = state_q;
      sw_d       = sw_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      idle_cnt_d = idle_cnt_q;

      if (clk_en) begin
         case (state_q)
            ST_IDLE: begin
               if (found) begin
                  sw_d    = winner;
                  state_d = ST_SWITCH;
               end
            end
            ST_SWITCH: begin
               // A withdrawn request abandons the switch even if the path matches now.
               if (!sel_req) state_d = ST_IDLE;
               else if (bus.curr_path == sw_q) state_d = ST_GRANT;
            end
            ST_GRANT: begin
               if (sel_hs) beat_cnt_d = beat_cnt_q + 1'b1;
               if (sel_req) idle_cnt_d = '0;
               else if (idle_cnt_q != CNT_SAT) idle_cnt_d = idle_cnt_q + 1'b1;
               if ((sel_hs && (sel_last || beat_cnt_q == BURST_LAST)) ||
                   (!sel_req && idle_cnt_q == IDLE_LAST)) begin
                  state_d = ST_RELEASE;
               end
            end
            ST_RELEASE: begin
               rr_ptr_d   = (sw_q == NSIZE'(NUM - 1)) ? '0 : sw_q + 1'b1;
               beat_cnt_d = '0;
               idle_cnt_d = '0;
               state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Outputs are decoded from the next state so they are registered
      // yet line up with the state register.
      vld_sw_d = (state_d == ST_GRANT);
      busy_d   = (state_d != ST_IDLE);
      grant_d  = '0;
      if (vld_sw_d) grant_d[sw_d] = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         sw_q       <= '0;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         idle_cnt_q <= '0;
         vld_sw_q   <= 1'b0;
         busy_q     <= 1'b0;
         grant_q    <= '0;
      end else begin
         state_q    <= state_d;
         sw_q       <= sw_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         vld_sw_q   <= vld_sw_d;
         busy_q     <= busy_d;
         grant_q    <= grant_d;
      end
   end

   assign bus.sw     = sw_q;
   assign bus.vld_sw = vld_sw_q;
   assign bus.grant  = grant_q;
   assign bus.busy   = busy_q;

endmodule

// File: tb/tb_data_pipe_m2s_arbiter.sv
// Testbench for data_pipe_m2s_arbiter (NUM=4, BURST_MAX=4, IDLE_TO=8).
// The interconnect is modelled as curr_path following sw one clock later.
module tb_data_pipe_m2s_arbiter;

   localparam int NUM       = 4;
   localparam int NSIZE     = 2;
   localparam int BURST_MAX = 4;
   localparam int IDLE_TO   = 8;

   logic clock;
   logic rst_n;
   logic clk_en;

   data_pipe_m2s_arbiter_if #(.NUM(NUM), .NSIZE(NSIZE)) bus ();

   data_pipe_m2s_arbiter #(
      .NUM       (NUM),
      .NSIZE     (NSIZE),
      .BURST_MAX (BURST_MAX),
      .IDLE_TO   (IDLE_TO)
   ) dut (
      .clock  (clock),
      .rst_n  (rst_n),
      .clk_en (clk_en),
      .bus    (bus)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial bus.curr_path = '0;
   always @(posedge clock) bus.curr_path <= bus.sw;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: phase 0=idle, 1=switching, 2=granted, 3=releasing.
   int m_phase = 0, m_sw = 0, m_rr = 0, m_beats = 0, m_idle = 0, m_pick;
   bit m_r, m_h, m_l, m_done;

   function automatic bit bit_at(input logic [NUM-1:0] v, input int i);
      return bit'(v >> i);
   endfunction

   always @(posedge clock) begin
      if (!rst_n) begin
         m_phase = 0; m_sw = 0; m_rr = 0; m_beats = 0; m_idle = 0;
      end else if (clk_en) begin
         m_r = bit_at(bus.req, m_sw);
         m_h = bit_at(bus.hs, m_sw);
         m_l = bit_at(bus.last, m_sw);
         case (m_phase)
            0: begin
               m_pick = -1;
               for (int k = 0; k < NUM; k++)
                  if (m_pick < 0 && bit_at(bus.req, (m_rr + k) % NUM)) m_pick = (m_rr + k) % NUM;
               if (m_pick >= 0) begin m_sw = m_pick; m_phase = 1; end
            end
            1: begin
               if (!m_r) m_phase = 0;
               else if (int'(bus.curr_path) == m_sw) m_phase = 2;
            end
            2: begin
               m_done = (m_h && (m_l || m_beats == BURST_MAX - 1)) || (!m_r && m_idle == IDLE_TO - 1);
               if (m_h) m_beats++;
               m_idle = m_r ? 0 : ((m_idle < 255) ? m_idle + 1 : 255);
               if (m_done) m_phase = 3;
            end
            default: begin
               m_rr = (m_sw + 1) % NUM;
               m_beats = 0; m_idle = 0; m_phase = 0;
            end
         endcase
      end
   end

   function automatic logic [7:0] dut_outs();
      return {bus.busy, bus.vld_sw, bus.grant, bus.sw};
   endfunction

   function automatic logic [7:0] model_outs();
      logic v;
      logic [NUM-1:0] g;
      v = (m_phase == 2);
      g = v ? NUM'(1 << m_sw) : '0;
      return {(m_phase != 0), v, g, NSIZE'(m_sw)};
   endfunction

   bit check_en = 0;
   always @(negedge clock) begin
      if (check_en) check("cycle_outputs", {24'd0, dut_outs()}, {24'd0, model_outs()});
   end

   // Stimulus controls
   logic           rst_v = 1'b0;
   logic [NUM-1:0] req_v = '0;
   int en_pct = 100, en_mode = 0, ready_pct = 100, last_beat = 0;
   bit last_rand = 0, junk = 0;
   int beats_acc = 0, last_grant_beats = -1;
   bit prev_vld = 0, cnt_now, last_en;
   int grant_log[$];

   task automatic tick();
      logic [NUM-1:0] hs_v, last_v;
      @(negedge clock);
      rst_n = rst_v;
      if (en_mode == 1) clk_en = ~clk_en;
      else clk_en = ($urandom_range(0, 99) < en_pct);
      bus.req = req_v;
      hs_v = '0;
      last_v = '0;
      for (int i = 0; i < NUM; i++) begin
         if (bit_at(bus.grant, i) && bit_at(req_v, i) && ($urandom_range(0, 99) < ready_pct)) begin
            hs_v = hs_v | NUM'(1 << i);
            if (((last_beat != 0) && (beats_acc + 1 == last_beat)) ||
                (last_rand && $urandom_range(0, 99) < 20))
               last_v = last_v | NUM'(1 << i);
         end else if (junk && !bit_at(bus.grant, i)) begin
            if ($urandom_range(0, 99) < 20) hs_v = hs_v | NUM'(1 << i);
            if ($urandom_range(0, 99) < 30) last_v = last_v | NUM'(1 << i);
         end
      end
      bus.hs   = hs_v;
      bus.last = last_v;
      cnt_now  = bus.vld_sw && bus.hs[bus.sw] && clk_en && rst_n;
      last_en  = clk_en;
      @(posedge clock);
      #1;
      if (cnt_now) beats_acc++;
      if (bus.vld_sw && !prev_vld) begin
         beats_acc = 0;
         grant_log.push_back(int'(bus.sw));
      end
      if (!bus.vld_sw && prev_vld) last_grant_beats = beats_acc;
      prev_vld = bus.vld_sw;
   endtask

   task automatic wait_vld(input logic level, input int max_ticks, input string name, output int n);
      n = 0;
      while (bus.vld_sw !== level && n < max_ticks) begin
         tick();
         n++;
      end
      if (bus.vld_sw !== level) check(name, {31'd0, bus.vld_sw}, {31'd0, level});
   endtask

   task automatic do_reset();
      rst_v = 1'b0;
      req_v = '0;
      tick();
      tick();
      rst_v = 1'b1;
      beats_acc = 0;
      grant_log.delete();
   endtask

   int n;
   logic [7:0] snap;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n = 1'b0;
      clk_en = 1'b1;
      bus.req = '0; bus.hs = '0; bus.last = '0;

      // Reset state
      do_reset();
      check_en = 1;
      check("reset_outputs", {24'd0, dut_outs()}, 32'd0);

      // Test 1: single requester 2, three beats ending with last
      req_v = 4'b0100; last_beat = 3;
      wait_vld(1'b1, 20, "t1_grant_timeout", n);
      check("t1_grant_latency", n, 3);
      check("t1_sw", {30'd0, bus.sw}, 2);
      wait_vld(1'b0, 20, "t1_release_timeout", n);
      check("t1_beats", last_grant_beats, 3);
      req_v = 4'b1001;
      wait_vld(1'b1, 20, "t1_rr_timeout", n);
      check("t1_rr_next_sw", {30'd0, bus.sw}, 3);
      check("t1_model_rr", m_rr, 3);
      last_beat = 1;
      wait_vld(1'b0, 20, "t1_end_timeout", n);
      $display("test1 single request: latency and rr_ptr checked");

      // Test 2: all requesting, one-beat packets
      do_reset();
      req_v = 4'b1111; last_beat = 1;
      n = 0;
      while (grant_log.size() < 5 && n < 300) begin tick(); n++; end
      for (int k = 0; k < 5; k++)
         check("t2_order", (k < grant_log.size()) ? grant_log[k] : -1, exp_order[k]);
      $display("test2 round robin order: %0d grants logged", grant_log.size());

      // Test 3: burst limit on continuous requester 1
      do_reset();
      req_v = 4'b0010; last_beat = 0;
      wait_vld(1'b1, 20, "t3_grant_timeout", n);
      wait_vld(1'b0, 40, "t3_release_timeout", n);
      check("t3_burst_beats", last_grant_beats, BURST_MAX);
      $display("test3 burst limit: %0d beats", last_grant_beats);

      // Test 4: idle timeout, then requester 3 wins
      do_reset();
      req_v = 4'b0001;
      wait_vld(1'b1, 20, "t4_grant_timeout", n);
      n = 0;
      while (beats_acc < 2 && n < 20) begin tick(); n++; end
      req_v = 4'b1000;
      wait_vld(1'b0, 40, "t4_idle_timeout", n);
      check("t4_idle_cycles", n, IDLE_TO);
      wait_vld(1'b1, 20, "t4_next_timeout", n);
      check("t4_next_sw", {30'd0, bus.sw}, 3);
      last_beat = 1;
      wait_vld(1'b0, 20, "t4_end_timeout", n);
      last_beat = 0;
      $display("test4 idle timeout: next owner %0d", bus.sw);

      // Test 5: clock enable toggling during a grant
      do_reset();
      req_v = 4'b0001;
      wait_vld(1'b1, 20, "t5_grant_timeout", n);
      en_mode = 1;
      n = 0;
      while (bus.vld_sw && n < 40) begin
         snap = dut_outs();
         tick();
         n++;
         if (!last_en) check("t5_hold", {24'd0, dut_outs()}, {24'd0, snap});
      end
      en_mode = 0;
      check("t5_ticks", n, 2 * BURST_MAX);
      check("t5_beats", last_grant_beats, BURST_MAX);
      $display("test5 clk_en toggle: %0d ticks in grant", n);

      // Test 6: reset mid-grant with clk_en low
      do_reset();
      req_v = 4'b0100;
      wait_vld(1'b1, 20, "t6_grant_timeout", n);
      tick();
      check("t6_pre_vld", {31'd0, bus.vld_sw}, 1);
      en_pct = 0; rst_v = 1'b0;
      tick();
      check("t6_after_reset", {29'd0, bus.busy, bus.vld_sw, bus.sw}, 0);
      en_pct = 100;
      $display("test6 reset mid-grant: vld_sw=%0d busy=%0d", bus.vld_sw, bus.busy);

      // Randomized run against the model
      do_reset();
      junk = 1; last_rand = 1; en_pct = 80; ready_pct = 70;
      for (int t = 0; t < 3000; t++) begin
         if ($urandom_range(0, 7) == 0) req_v = NUM'($urandom_range(0, 15));
         rst_v = ($urandom_range(0, 599) != 0);
         tick();
      end
      rst_v = 1'b1;
      tick();
      $display("random run: %0d grants", grant_log.size());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/data_pipe_m2s_arbiter.md
DATA_PIPE_M2S_ARBITER -- requirements
Module: data_pipe_m2s_arbiter

Interface
REQ-001 Parameter NUM, default 8, number of upstream requesters (2..32).
REQ-002 Parameter NSIZE, default derived as ceil(log2(NUM)) with minimum 1, width of path index.
REQ-003 Parameter BURST_MAX, default 16, maximum beats per grant (1..255).
REQ-004 Parameter IDLE_TO, default 8, consecutive idle cycles before a granted requester loses the grant (1..255).
REQ-005 clock  input  1  clock; rst_n  input  1  reset, synchronous, active-low.
REQ-006 clk_en  input  1  clock enable; the FSM and all counters advance only when high.
REQ-007 req  input  NUM  per-requester valid taps (s00[i].valid).
REQ-008 hs  input  NUM  per-requester accepted beat (s00[i].valid & s00[i].ready).
REQ-009 last  input  NUM  per-requester end-of-packet flag, qualified by hs.
REQ-010 curr_path  input  NSIZE  path currently latched by the M2S interconnect.
REQ-011 sw  output  NSIZE  path selection to the interconnect.
REQ-012 vld_sw  output  1  enables upstream ready on the selected path.
REQ-013 grant  output  NUM  one-hot of sw while vld_sw=1, otherwise all zeros.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have 4 states: IDLE, SWITCH, GRANT and RELEASE.
REQ-016 IDLE: when clk_en and |req, the block SHALL pick a winner by round-robin starting at rr_ptr, load sw with it and go to SWITCH.
REQ-017 Round-robin search SHALL check indices rr_ptr, rr_ptr+1, ... with wrap modulo NUM; rr_ptr resets to 0.
REQ-018 SWITCH: vld_sw SHALL be 0; the block SHALL go to GRANT on the first clk_en cycle where curr_path==sw.
REQ-019 SWITCH: if req[sw] drops before the match, the block SHALL return to IDLE without granting.
REQ-020 GRANT: vld_sw SHALL be 1 and beat_cnt SHALL increment on each hs[sw] while clk_en.
REQ-021 GRANT SHALL exit to RELEASE on hs[sw]&last[sw], or hs[sw] with beat_cnt==BURST_MAX-1, or idle_cnt reaching IDLE_TO-1 with req[sw]=0.
REQ-022 idle_cnt SHALL clear on any cycle where req[sw]=1 and increment otherwise, saturating.
REQ-023 hs or last on a non-selected index SHALL be ignored.
REQ-024 RELEASE: vld_sw SHALL be 0 for exactly one clk_en cycle, rr_ptr SHALL become (sw+1) mod NUM, and beat_cnt and idle_cnt SHALL clear; then the block SHALL go to IDLE.
REQ-025 While in RELEASE, IDLE or SWITCH, sw SHALL hold its value.
REQ-026 When clk_en=0, state, sw, counters and vld_sw SHALL hold their values.
REQ-027 If only the previous owner requests, it SHALL be re-granted after the RELEASE/IDLE cycles, so no requester starves.
REQ-028 The worst-case grant latency for a requester SHALL be bounded by (NUM-1)*(BURST_MAX+IDLE_TO+3) clk_en cycles.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 Under reset, state SHALL be IDLE, and sw, rr_ptr, beat_cnt and idle_cnt SHALL be 0.
REQ-031 Under reset, vld_sw, grant and busy SHALL be 0.
REQ-032 Reset asserted mid-GRANT SHALL drop vld_sw on the next edge regardless of clk_en.

Structure
REQ-033 The STATE enum and the NSIZE derivation function SHALL live in shared package data_pipe_pkg, reused by data_pipe_interconnect_M2S.
REQ-034 The round-robin search SHALL be one combinational sub-module, rr_pick (inputs req, rr_ptr; outputs winner, found).

Verification
REQ-035 Test 1: NUM=4, req=4'b0100, curr_path follows sw after 2 cycles -> sw=2, vld_sw=1 on the 3rd cycle; 3 beats ending with last -> RELEASE, rr_ptr=3.
REQ-036 Test 2: req=4'b1111 held, always last on beat 1 -> grant order 0,1,2,3,0.
REQ-037 Test 3: BURST_MAX=4, req[1] continuous, no last -> exactly 4 hs beats are accepted, then vld_sw=0 for 1 cycle.
REQ-038 Test 4: IDLE_TO=8, grant to 0, req[0] drops after beat 2 -> RELEASE after 8 idle cycles; req[3] is granted next.
REQ-039 Test 5: toggle clk_en 1/0 during GRANT -> beat_cnt advances only on enabled cycles, and outputs are stable when clk_en=0.
REQ-040 Test 6: assert rst_n=0 mid-GRANT with clk_en=0 -> next cycle vld_sw=0, sw=0, busy=0.
